// File: rtl/tt_um_simple_clock.sv
// 24-hour BCD clock for Tiny Tapeout: 1 Hz prescaler, cascaded sec/min/hour
// counters, debounced-by-sync set buttons, pause/clear and a display mux.
module tt_um_simple_clock #(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

  logic          fast;
  logic [1:0]    sel;
  logic          pause;
  logic          clr;
  logic          tick;
  logic [PW-1:0] presc;

  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hr;

  logic       min_s1, min_s2, min_prev, min_arm;
  logic       hr_s1, hr_s2, hr_prev, hr_arm;
  logic [1:0] fill;
  logic       min_evt, hr_evt;
  logic       min_carry, hr_carry;
  logic       unused_ok;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign fast  = ui_in[0];
  assign sel   = ui_in[2:1];
  assign pause = ui_in[5];
  assign clr   = ui_in[6];
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7]};

  assign tick = ~pause & ~clr & (fast | (presc == PMAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      presc <= '0;
    else if (clr || fast)
      presc <= '0;
    else if (pause)
      presc <= presc;
    else if (presc == PMAX)
      presc <= '0;
    else
      presc <= presc + PW'(1);
  end

  // A button must be seen released after reset (arm) before a press counts,
  // so a button held through reset does not register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {min_s1, min_s2, min_prev, min_arm} <= '0;
      {hr_s1, hr_s2, hr_prev, hr_arm}     <= '0;
      fill                                <= '0;
    end else begin
      min_s1   <= ui_in[3];
      min_s2   <= min_s1;
      min_prev <= min_s2;
      min_arm  <= min_arm | (fill[1] & ~min_s2);
      hr_s1    <= ui_in[4];
      hr_s2    <= hr_s1;
      hr_prev  <= hr_s2;
      hr_arm   <= hr_arm | (fill[1] & ~hr_s2);
      fill     <= {fill[0], 1'b1};
    end
  end

  assign min_evt   = fill[1] & min_arm & min_s2 & ~min_prev;
  assign hr_evt    = fill[1] & hr_arm & hr_s2 & ~hr_prev;
  assign min_carry = tick & (sec == 8'h59);
  assign hr_carry  = min_carry & (min == 8'h59);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec <= 8'h00;
      min <= 8'h00;
      hr  <= 8'h00;
    end else begin
      if (clr)
        sec <= 8'h00;
      else if (tick)
        sec <= bcd_inc(sec, 8'h59);
      if (min_carry || min_evt)
        min <= bcd_inc(min, 8'h59);
      if (hr_carry || hr_evt)
        hr <= bcd_inc(hr, 8'h23);
    end
  end

  always_comb begin
    uo_out = sec;
    unique case (sel)
      2'b00: uo_out = sec;
      2'b01: uo_out = min;
      2'b10: uo_out = hr;
      2'b11: uo_out = {min[3:0], sec[3:0]};
    endcase
  end

  assign uio_out = rst_n ? {5'b0, pause, sec[0], tick} : 8'h00;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_simple_clock.sv
// Directed scoreboard bench for tt_um_simple_clock (CLK_HZ=5 instance).
module tb_tt_um_simple_clock;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  string       name_q[$];
  logic [15:0] exp_q[$];

  tt_um_simple_clock #(.CLK_HZ(5)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] st(input bit p, input bit l, input bit t);
    return {5'b0, p, l, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected response is checked at the next falling edge
  task automatic ex(input string n, input logic [7:0] uo, input logic [7:0] uio);
    name_q.push_back(n);
    exp_q.push_back({uo, uio});
  endtask

  task automatic press(input int bitn, input int n);
    for (int k = 0; k < n; k++) begin
      ui_in[bitn] = 1'b1;
      repeat (3) step();
      ui_in[bitn] = 1'b0;
      repeat (3) step();
    end
  endtask

  string       mon_name;
  logic [15:0] mon_exp;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_name = name_q.pop_front();
      mon_exp  = exp_q.pop_front();
      checks++;
      if (uo_out !== mon_exp[15:8] || uio_out !== mon_exp[7:0] || uio_oe !== 8'hFF) begin
        errors++;
        $display("FAIL %s: got uo_out=%h uio_out=%h uio_oe=%h, expected uo_out=%h uio_out=%h uio_oe=ff",
                 mon_name, uo_out, uio_out, uio_oe, mon_exp[15:8], mon_exp[7:0]);
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    bit p;
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    step();

    for (int s = 0; s < 4; s++) begin
      ui_in      = 8'($urandom);
      ui_in[2:1] = 2'(s);
      ex("reset_hold", 8'h00, 8'h00);
      step();
    end

    // fast count from reset
    ui_in = 8'h01;
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ex("fast_sec", bcd(i), st(0, bit'(i & 1), 1));
      step();
    end
    ui_in = 8'h23;
    ex("min_after_60", 8'h01, st(1, 0, 0));
    step();

    // minute button pulses and hour button hold
    for (int k = 0; k < 10; k++) begin
      ui_in = 8'h2A;
      repeat (4) step();
      ui_in = 8'h22;
      repeat (4) step();
    end
    ex("min_pulses", 8'h11, st(1, 0, 0));
    step();
    ui_in = 8'h24;
    ex("hr_after_pulses", 8'h00, st(1, 0, 0));
    step();
    ui_in = 8'h34;
    repeat (100) step();
    ui_in = 8'h24;
    repeat (4) step();
    ex("hr_hold_once", 8'h01, st(1, 0, 0));
    step();
    ui_in = 8'h22;
    ex("min_after_hold", 8'h11, st(1, 0, 0));
    step();

    // button latency: increment on the third edge
    ui_in = 8'h2A;
    ex("lat_edge0", 8'h11, st(1, 0, 0));
    step();
    ex("lat_edge1", 8'h11, st(1, 0, 0));
    step();
    ex("lat_edge2", 8'h11, st(1, 0, 0));
    step();
    ex("lat_edge3", 8'h12, st(1, 0, 0));
    step();
    ui_in = 8'h22;
    repeat (3) step();

    // set 23:59, then minute press at 59 must not carry
    press(4, 22);
    press(3, 47);
    ex("min_59", 8'h59, st(1, 0, 0));
    step();
    ui_in = 8'h24;
    ex("hr_23", 8'h23, st(1, 0, 0));
    step();
    press(3, 1);
    ui_in = 8'h22;
    ex("min_btn_wrap", 8'h00, st(1, 0, 0));
    step();
    ui_in = 8'h24;
    ex("hr_no_btn_carry", 8'h23, st(1, 0, 0));
    step();
    ui_in = 8'h22;
    press(3, 59);
    ex("min_back_59", 8'h59, st(1, 0, 0));
    step();

    // full rollover 23:59:59 -> 00:00:00 on one edge
    ui_in = 8'h01;
    for (int i = 0; i < 59; i++) begin
      ex("roll_sec", bcd(i), st(0, bit'(i & 1), 1));
      step();
    end
    ui_in = 8'h07;
    ex("roll_pre_mmss", 8'h99, st(0, 1, 1));
    step();
    ui_in = 8'h21;
    ex("roll_sec0", 8'h00, st(1, 0, 0));
    step();
    ui_in = 8'h23;
    ex("roll_min0", 8'h00, st(1, 0, 0));
    step();
    ui_in = 8'h25;
    ex("roll_hr0", 8'h00, st(1, 0, 0));
    step();

    // pause holds seconds; clear zeroes them
    ui_in = 8'h01;
    for (int i = 0; i < 7; i++) begin
      ex("to_07", bcd(i), st(0, bit'(i & 1), 1));
      step();
    end
    ui_in = 8'h21;
    for (int i = 0; i < 20; i++) begin
      ex("pause_hold", 8'h07, st(1, 1, 0));
      step();
    end
    ui_in = 8'h61;
    ex("clear_latency", 8'h07, st(1, 1, 0));
    step();
    ui_in = 8'h21;
    ex("cleared", 8'h00, st(1, 0, 0));
    step();

    // prescaler divide-by-5 with a 3-cycle pause mid-count
    ui_in = 8'h40;
    step();
    run = 0;
    for (int c = 0; c < 25; c++) begin
      p = (c >= 12 && c < 15);
      ui_in = p ? 8'h20 : 8'h00;
      ex("prescale", bcd(run / 5), st(p, bit'((run / 5) & 1), !p && (run % 5 == 4)));
      step();
      if (!p) run++;
    end

    // async reset mid-count with a held button
    ui_in = 8'h22;
    press(3, 1);
    ui_in = 8'h2A;
    repeat (4) step();
    ex("min_pre_rst", 8'h02, st(1, 0, 0));
    step();
    rst_n = 1'b0;
    ex("rst_async", 8'h00, 8'h00);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ex("held_through_rst", 8'h00, st(1, 0, 0));
      step();
    end
    ui_in = 8'h22;
    repeat (3) step();
    ui_in = 8'h2A;
    repeat (3) step();
    ui_in = 8'h22;
    ex("repress_after_rst", 8'h01, st(1, 0, 0));
    step();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
